// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: register index width, controller
// states and the opcode constants the decoder uses to classify instructions.
package core_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    MEM_WAIT
  } ctrl_state_t;

  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_JAL   = 6'h03;

  function automatic logic op_is_load(input logic [5:0] op);
    return op == OP_LOAD;
  endfunction

  function automatic logic op_is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipe: load-use bubbles, taken-branch
// squashes and data-memory wait freezes, plus stall/flush performance counters.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);

  ctrl_state_t state_q, state_d;
  ctrl_state_t ret_q, ret_d;
  logic [2:0]  bub_q, bub_d;
  logic        load_use;
  logic        mem_wait;
  logic        flush_ev;

  assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));
  assign mem_wait = mem_req && !mem_ack;

  always_comb begin
    pc_en       = 1'b1;
    pc_sel      = 1'b0;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    flush_ev    = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    bub_d       = bub_q;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_wait) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            ret_d   = RUN;
            state_d = MEM_WAIT;
          end else if (ex_valid && ex_branch_taken) begin
            // ID instruction is squashed, so a coincident load-use is moot
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_ev    = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            bub_d       = BUB_INIT;
            if (LOAD_LAT > 1) state_d = LD_STALL;
          end
        end
        LD_STALL: begin
          if (mem_wait) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            ret_d   = LD_STALL;
            state_d = MEM_WAIT;
          end else begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            bub_d       = bub_q - 1'b1;
            if (bub_q <= 3'd1) state_d = RUN;
          end
        end
        MEM_WAIT: begin
          if (!mem_ack) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          end else begin
            state_d = ret_q;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_ev),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: expected control vectors are queued as each step is driven and
// compared when the DUT outputs are sampled; two instances cover LOAD_LAT 1 and 3.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic       id_valid, id_use_rn, id_use_rm;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       ex_valid, ex_is_load, ex_branch_taken, mem_req, mem_ack;

  logic        pc_en1, pc_sel1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, ex_mem_en1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic        pc_en3, pc_sel3, if_id_en3, if_id_flush3, id_ex_en3, id_ex_flush3, ex_mem_en3;
  logic [2:0]  stall_cnt3, flush_cnt3;

  int checks = 0;
  int errors = 0;
  int active = 1;
  logic [6:0] exp_q[$];

  // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [6:0] V_RUN = 7'b1010101;
  localparam logic [6:0] V_RST = 7'b0001010;
  localparam logic [6:0] V_LU  = 7'b0000111;
  localparam logic [6:0] V_BR  = 7'b1111111;
  localparam logic [6:0] V_FRZ = 7'b0000000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_en(pc_en1), .pc_sel(pc_sel1), .if_id_en(if_id_en1),
    .if_id_flush(if_id_flush1), .id_ex_en(id_ex_en1), .id_ex_flush(id_ex_flush1),
    .ex_mem_en(ex_mem_en1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst3), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_en(pc_en3), .pc_sel(pc_sel3), .if_id_en(if_id_en3),
    .if_id_flush(if_id_flush3), .id_ex_en(id_ex_en3), .id_ex_flush(id_ex_flush3),
    .ex_mem_en(ex_mem_en3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  function automatic logic [6:0] outs();
    if (active == 1)
      return {pc_en1, pc_sel1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_flush1, ex_mem_en1};
    return {pc_en3, pc_sel3, if_id_en3, if_id_flush3, id_ex_en3, id_ex_flush3, ex_mem_en3};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are already applied; queue the expectation, compare mid-cycle, then advance.
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {9'd0, outs()}, {9'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_use_rn = 0; id_use_rm = 0; id_rn = 0; id_rm = 0;
    ex_valid = 0; ex_is_load = 0; ex_branch_taken = 0; ex_rd = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  task automatic load_r3();
    id_valid = 1; id_rn = 5'd3; id_use_rn = 1; id_rm = 5'd7; id_use_rm = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd3;
  endtask

  initial begin
    idle_inputs();
    rst1 = 1; rst3 = 1;
    #1;
    // ---- LOAD_LAT = 1 instance ----
    step("reset_outputs", V_RST);
    @(negedge clk);
    chk("reset_stall_cnt", stall_cnt1, 16'd0);
    chk("reset_flush_cnt", flush_cnt1, 16'd0);
    @(posedge clk); #1;
    rst1 = 0;
    step("idle", V_RUN);

    load_r3();
    step("load_use_rn", V_LU);
    idle_inputs();
    step("after_load_use", V_RUN);
    chk("stall_cnt_1", stall_cnt1, 16'd1);

    load_r3(); ex_rd = 5'd0; id_rn = 5'd0; id_rm = 5'd0;
    step("r0_no_hazard", V_RUN);
    load_r3(); id_use_rn = 0; id_use_rm = 0;
    step("no_use_no_hazard", V_RUN);
    load_r3(); id_valid = 0;
    step("id_invalid_no_hazard", V_RUN);
    load_r3(); id_use_rn = 0; id_rm = 5'd3;
    step("load_use_rm", V_LU);
    idle_inputs();
    step("after_rm_hazard", V_RUN);

    load_r3(); ex_branch_taken = 1;
    step("branch_over_load_use", V_BR);
    idle_inputs();
    step("after_branch", V_RUN);
    chk("flush_cnt_1", flush_cnt1, 16'd1);
    chk("stall_cnt_after_branch", stall_cnt1, 16'd2);

    mem_req = 1; ex_valid = 1; ex_branch_taken = 1;
    step("mem_over_branch", V_FRZ);
    ex_valid = 0; ex_branch_taken = 0;
    for (int i = 0; i < 3; i++) step("mem_wait", V_FRZ);
    mem_ack = 1;
    step("mem_ack_release", V_RUN);
    idle_inputs();
    step("after_mem", V_RUN);
    chk("stall_cnt_mem4", stall_cnt1, 16'd6);
    chk("flush_cnt_mem", flush_cnt1, 16'd1);

    mem_req = 1;
    step("mem_wait_pre_reset", V_FRZ);
    rst1 = 1;
    step("reset_in_wait", V_RST);
    rst1 = 0; mem_req = 0;
    step("run_after_reset", V_RUN);
    chk("stall_cnt_cleared", stall_cnt1, 16'd0);
    chk("flush_cnt_cleared", flush_cnt1, 16'd0);

    // ---- LOAD_LAT = 3 instance, 3-bit counters ----
    rst1 = 1; rst3 = 0; active = 3;
    step("lat3_idle", V_RUN);
    load_r3();
    step("lat3_hazard", V_LU);
    idle_inputs();
    step("lat3_ld_stall_1", V_LU);
    mem_req = 1;
    step("lat3_wait_1", V_FRZ);
    step("lat3_wait_2", V_FRZ);
    mem_ack = 1;
    step("lat3_ack", V_RUN);
    idle_inputs();
    step("lat3_ld_stall_2", V_LU);
    step("lat3_back_to_run", V_RUN);
    chk("lat3_stall_cnt_5", {13'd0, stall_cnt3}, 16'd5);

    mem_req = 1;
    for (int i = 0; i < 4; i++) step("lat3_sat_wait", V_FRZ);
    mem_ack = 1;
    step("lat3_sat_ack", V_RUN);
    idle_inputs();
    @(negedge clk);
    chk("lat3_stall_cnt_sat", {13'd0, stall_cnt3}, 16'd7);
    chk("lat3_flush_cnt", {13'd0, flush_cnt3}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
